// File: rtl/snn_ctrl_pkg.sv
// Shared types and constants for the SNN inference controller.
// Holds the sequencer state encoding and the limit on spike latency.
package snn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    ARGMAX,
    DONE
  } state_e;

  localparam int MAX_SPIKE_LAT = 8;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_argmax_seq.sv
// Sequential argmax over packed spike counters, one neuron per cycle.
// A neuron replaces the best only when strictly greater, so ties go to the lowest index.
module spike_argmax_seq
  import snn_ctrl_pkg::*;
#(
  parameter int NUM   = 3,
  parameter int CNT_W = 8,
  parameter int IDX_W = idx_width(NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [NUM*CNT_W-1:0] counts,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     winner,
  output logic                 max_nz
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] bidx_q, bidx_d;
  logic [CNT_W-1:0] best_q, best_d;
  logic             active_q, active_d;

  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] cur_bidx;
  logic [CNT_W-1:0] cur_best;
  logic [CNT_W-1:0] cand;
  logic             scanning;
  logic             last;

  // The start cycle already scans neuron 0 against an empty best.
  always_comb begin
    cur_idx  = start ? '0 : idx_q;
    cur_bidx = start ? '0 : bidx_q;
    cur_best = start ? '0 : best_q;
    cand     = counts[cur_idx*CNT_W +: CNT_W];
    scanning = start || active_q;
    last     = (cur_idx == IDX_W'(NUM - 1));

    idx_d    = idx_q;
    bidx_d   = bidx_q;
    best_d   = best_q;
    active_d = active_q;
    done     = 1'b0;

    if (abort) begin
      active_d = 1'b0;
    end else if (scanning) begin
      if (cand > cur_best) begin
        best_d = cand;
        bidx_d = cur_idx;
      end else begin
        best_d = cur_best;
        bidx_d = cur_bidx;
      end
      idx_d    = last ? '0 : cur_idx + IDX_W'(1);
      active_d = !last;
      done     = last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q    <= '0;
      bidx_q   <= '0;
      best_q   <= '0;
      active_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      bidx_q   <= bidx_d;
      best_q   <= best_d;
      active_q <= active_d;
    end
  end

  assign busy   = active_q;
  assign winner = bidx_d;
  assign max_nz = (best_d != '0);

endmodule

// File: rtl/snn_inference_controller.sv
// Sequences one inference: clear, drive stimulus for N steps, count layer-2 spikes
// over a latency-aligned window, then pick the winning neuron.
module snn_inference_controller
  import snn_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_OUT   = 3,
  parameter int STEP_W    = 16,
  parameter int CNT_W     = 8,
  parameter int SPIKE_LAT = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  input  logic [STEP_W-1:0]               num_steps,
  input  logic signed [WIDTH-1:0]         stim_current,
  output logic                            nn_clear,
  output logic signed [WIDTH-1:0]         nn_current,
  input  logic [NUM_OUT-1:0]              spikes_in,
  output logic                            busy,
  output logic                            done,
  output logic [NUM_OUT*CNT_W-1:0]        spike_counts,
  output logic [idx_width(NUM_OUT)-1:0]   winner,
  output logic                            winner_valid
);

  localparam int LAT     = (SPIKE_LAT > MAX_SPIKE_LAT) ? MAX_SPIKE_LAT : SPIKE_LAT;
  localparam int IDX_W   = idx_width(NUM_OUT);
  localparam int DRAIN_W = 4;

  state_e                   state_q, state_d;
  logic [STEP_W-1:0]        step_q, step_d;
  logic signed [WIDTH-1:0]  stim_q, stim_d;
  logic [DRAIN_W-1:0]       drain_q, drain_d;
  logic [IDX_W-1:0]         win_q, win_d;
  logic                     wv_q, wv_d;

  logic [CNT_W-1:0]         cnt_q [NUM_OUT];
  logic [CNT_W-1:0]         cnt_d [NUM_OUT];
  logic [NUM_OUT*CNT_W-1:0] counts_flat;

  logic             in_run;
  logic             abort_now;
  logic             count_en;
  logic             count_hit;
  logic             clr;
  logic             arg_start, arg_busy, arg_done, arg_nz;
  logic [IDX_W-1:0] arg_winner;

  assign in_run    = (state_q == RUN);
  assign abort_now = abort && (state_q != IDLE);
  assign clr       = (state_q == CLEAR);
  assign count_hit = count_en && !abort_now;

  // Run flag delayed by the network latency so the window spans exactly N cycles.
  generate
    if (LAT == 0) begin : g_nolat
      assign count_en = in_run;
    end else begin : g_lat
      logic [LAT-1:0] dl_q, dl_d;
      assign dl_d     = abort_now ? '0 : LAT'({dl_q, in_run});
      assign count_en = dl_q[LAT-1];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) dl_q <= '0;
        else      dl_q <= dl_d;
      end
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_cnt
      assign cnt_d[gi] = clr ? '0 :
                         (count_hit && spikes_in[gi] && (cnt_q[gi] != '1)) ?
                         cnt_q[gi] + CNT_W'(1) : cnt_q[gi];
      assign counts_flat[gi*CNT_W +: CNT_W] = cnt_q[gi];
    end
  endgenerate

  assign arg_start = (state_q == ARGMAX) && !arg_busy;

  spike_argmax_seq #(
    .NUM   (NUM_OUT),
    .CNT_W (CNT_W),
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk    (clk),
    .rst    (rst),
    .start  (arg_start),
    .abort  (abort_now),
    .counts (counts_flat),
    .busy   (arg_busy),
    .done   (arg_done),
    .winner (arg_winner),
    .max_nz (arg_nz)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    stim_d  = stim_q;
    drain_d = drain_q;
    win_d   = win_q;
    wv_d    = wv_q;

    if (abort_now) begin
      state_d = IDLE;
      wv_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = CLEAR;
            step_d  = num_steps;
            stim_d  = stim_current;
          end
        end
        CLEAR: begin
          win_d   = '0;
          wv_d    = 1'b0;
          state_d = (step_q == '0) ? ARGMAX : RUN;
        end
        RUN: begin
          if (step_q == STEP_W'(1)) begin
            if (LAT == 0) begin
              state_d = ARGMAX;
            end else begin
              state_d = DRAIN;
              drain_d = DRAIN_W'(LAT - 1);
            end
          end else begin
            step_d = step_q - STEP_W'(1);
          end
        end
        DRAIN: begin
          if (drain_q == '0) state_d = ARGMAX;
          else               drain_d = drain_q - DRAIN_W'(1);
        end
        ARGMAX: begin
          if (arg_done) begin
            win_d   = arg_winner;
            wv_d    = arg_nz;
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      stim_q  <= '0;
      drain_q <= '0;
      win_q   <= '0;
      wv_q    <= 1'b0;
      for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      stim_q  <= stim_d;
      drain_q <= drain_d;
      win_q   <= win_d;
      wv_q    <= wv_d;
      for (int i = 0; i < NUM_OUT; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign nn_clear     = (state_q == CLEAR);
  assign nn_current   = in_run ? stim_q : '0;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign spike_counts = counts_flat;
  assign winner       = win_q;
  assign winner_valid = wv_q;

endmodule
